// File: rtl/mips_fetch_stage_if.sv
// rtl/mips_fetch_stage_if.sv - instruction-memory read bus between fetch stage and imem
interface mips_fetch_stage_if #(
    parameter int IMEM_AW = 8
);
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;

    // Fetch stage drives the word address and consumes the same-cycle read data.
    modport master (
        output imem_addr,
        input  imem_rdata
    );

    // Instruction memory answers the address combinationally.
    modport slave (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/mips_fetch_stage.sv
// rtl/mips_fetch_stage.sv - MIPS instruction fetch stage with PC and IF/ID pipeline register
module mips_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                redirect,
    input  logic [31:0]         redirect_target,
    mips_fetch_stage_if.master  imem,
    output logic [31:0]         pc,
    output logic [31:0]         if_id_instr,
    output logic [31:0]         if_id_pc_plus4,
    output logic                if_id_valid,
    output logic [15:0]         fetch_count
);

    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;
    logic        accept;

    // The 32-bit add wraps naturally, so 32'hFFFF_FFFC steps to 0.
    assign pc_plus4       = pc + 32'd4;
    // Branch/jump destinations are always forced to a word boundary.
    assign target_aligned = redirect_target & 32'hFFFF_FFFC;
    // A new real instruction enters IF/ID only when nothing redirects or stalls.
    assign accept         = !redirect && !stall;

    // Unregistered word address: out-of-range PCs simply wrap by truncation.
    assign imem.imem_addr = pc[IMEM_AW+1:2];

    // PC register: reset, then redirect, then stall hold, then sequential advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target_aligned;
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

    // IF/ID latch: a redirect flushes to a bubble even when a stall is also requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (redirect) begin
            if_id_instr    <= 32'h0;
            if_id_pc_plus4 <= 32'h0;
            if_id_valid    <= 1'b0;
        end else if (!stall) begin
            if_id_instr    <= imem.imem_rdata;
            if_id_pc_plus4 <= pc_plus4;
            if_id_valid    <= 1'b1;
        end
    end

    // Saturating count of instructions accepted into IF/ID.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count <= 16'h0;
        end else if (accept && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mips_fetch_stage.sv
// tb/tb_mips_fetch_stage.sv - directed vector bench for mips_fetch_stage
module tb_mips_fetch_stage;

    localparam int AW = 8;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] fetch_count;

    logic [31:0] imem [256];

    int checks;
    int failures;

    mips_fetch_stage_if #(.IMEM_AW(AW)) bus ();

    assign bus.imem_rdata = imem[bus.imem_addr];

    mips_fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem            (bus.master),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redirect;
        logic [31:0] target;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_pc4;
        logic        e_valid;
        logic [15:0] e_cnt;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pc4, input logic e_valid, input logic [15:0] e_cnt);
        logic [AW-1:0] e_addr;
        e_addr = e_pc[AW+1:2];
        check({tag, " pc"},        pc,                     e_pc);
        check({tag, " imem_addr"}, {24'h0, bus.imem_addr}, {24'h0, e_addr});
        check({tag, " instr"},     if_id_instr,            e_instr);
        check({tag, " pc_plus4"},  if_id_pc_plus4,         e_pc4);
        check({tag, " valid"},     {31'h0, if_id_valid},   {31'h0, e_valid});
        check({tag, " count"},     {16'h0, fetch_count},   {16'h0, e_cnt});
    endtask

    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        @(negedge clk);
        rst             = r;
        stall           = s;
        redirect        = d;
        redirect_target = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int k = 0; k < 256; k++) imem[k] = 32'h1000_0000 + k;

        //            rst   stall redir target        pc            instr         pc4           v     cnt
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 16'd1};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 16'd2};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h8,        32'h1000_0001, 32'h8,       1'b1, 16'd2};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h1000_0002, 32'hC,       1'b1, 16'd3};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'h1000_0003, 32'h10,      1'b1, 16'd4};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h43,       32'h40,       32'h0,         32'h0,       1'b0, 16'd4};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h44,       32'h1000_0010, 32'h44,      1'b1, 16'd5};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h48,       32'h1000_0011, 32'h48,      1'b1, 16'd6};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 32'h20,       32'h20,       32'h0,         32'h0,       1'b0, 16'd6};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h24,       32'h1000_0008, 32'h24,      1'b1, 16'd7};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h24,       32'h1000_0008, 32'h24,      1'b1, 16'd7};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h24,       32'h1000_0008, 32'h24,      1'b1, 16'd7};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h0,       32'h0,       1'b0, 16'd7};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h1000_00FF, 32'h0,       1'b1, 16'd8};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 16'd9};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 32'h400,      32'h400,      32'h0,         32'h0,       1'b0, 16'd9};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h404,      32'h1000_0000, 32'h404,     1'b1, 16'd10};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h404,      32'h1000_0000, 32'h404,     1'b1, 16'd10};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 32'h80,       32'h0,        32'h0,         32'h0,       1'b0, 16'd0};
        vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 16'd1};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 32'h80,       32'h0,        32'h0,         32'h0,       1'b0, 16'd0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h1000_0000, 32'h4,       1'b1, 16'd1};

        // Reset with X on stall/redirect: reset must override and produce clean values.
        rst             = 1'b1;
        stall           = 1'bx;
        redirect        = 1'bx;
        redirect_target = 32'hx;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("reset", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].rst, vecs[i].stall, vecs[i].redirect, vecs[i].target);
            check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr,
                      vecs[i].e_pc4, vecs[i].e_valid, vecs[i].e_cnt);
        end

        // Free run far enough to reach the counter ceiling; count is 1 after the last vector.
        for (int n = 0; n < 65540; n++) step(1'b0, 1'b0, 1'b0, 32'h0);
        check("sat count", {16'h0, fetch_count}, 32'h0000_FFFF);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check("sat hold", {16'h0, fetch_count}, 32'h0000_FFFF);
        check("sat valid", {31'h0, if_id_valid}, 32'h1);

        // Reset in the middle of a running stream clears everything on that edge.
        step(1'b1, 1'b0, 1'b0, 32'h0);
        check_all("midrst", 32'h0, 32'h0, 32'h0, 1'b0, 16'd0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        check_all("resume", 32'h4, 32'h1000_0000, 32'h4, 1'b1, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
